ro_freq_monitor: RTL and testbench
==================================

// Module: ro_freq_monitor
// PURPOSE
//  Parametrised N-channel ring-oscillator frequency monitor; successor to the single-channel
//  ring-oscillator conduit in the Nios II system. Counts rising edges of each async ro_in[i]
//  over a programmable window of clk_clk cycles and latches the results into readable registers.
//  Avalon-MM slave on the Nios II data bus; the selected channel also drives a 32-bit export conduit.
// PARAMETERS
//  NUM_CH      4    number of ring-oscillator channels (1..16)
//  CNT_W       32   edge-counter width per channel (<=32, saturating)
//  ADDR_W      5    Avalon word-address width (needs 4+NUM_CH <= 2**ADDR_W)
//  WIN_DEFAULT 1000 reset value of the WINDOW register (clk_clk cycles)
// PORTS
//  clk_clk        in   1       system clock
//  reset_reset_n  in   1       async active-low reset
//  avs_address    in   ADDR_W  word address
//  avs_read       in   1       read strobe
//  avs_write      in   1       write strobe
//  avs_writedata  in   32      write data
//  avs_readdata   out  32      read data, valid 1 cycle after avs_read
//  ro_in          in   NUM_CH  async oscillator inputs
//  irq            out  1       level interrupt = DONE & IRQ_EN
//  export_data    out  32      latched COUNT[CH_SEL], zero-extended
// BEHAVIOUR
//  Map: 0 CTRL[0]=START(self-clr) [1]=CONT [2]=IRQ_EN [3]=ABORT(self-clr); 1 STATUS[0]=BUSY(ro)
//   [1]=DONE(sticky,W1C) [2]=OVF(sticky,W1C); 2 WINDOW[31:0]; 3 CH_SEL; 4+i COUNT[i](ro).
//   Unmapped reads return 0; unmapped writes ignored. Read latency exactly 1 cycle, no waitrequest.
//  Reset: readdata=0, irq=0, export_data=0, all COUNT=0, CTRL=0, STATUS=0, CH_SEL=0,
//   WINDOW=WIN_DEFAULT, FSM=IDLE, sync flops=0.
//  Input path per channel: 2-flop synchroniser + delay flop; edge = s2 & ~s3. Only correct for
//   f_ro < f_clk/2 (external divider assumed in the oscillator; not this block's concern).
//  FSM: IDLE -START-> ARM (1 cycle: clear live counters, load win_cnt=max(WINDOW,1))
//   -> COUNT (count edges, win_cnt-- each cycle) -win_cnt==1-> LATCH (1 cycle: COUNT[i]<=live[i],
//   DONE<=1, OVF|=any saturated) -> ARM if CONT else IDLE. BUSY=1 in ARM/COUNT/LATCH.
//  Window of W counts edges seen in exactly W consecutive cycles of COUNT.
//  Live counters saturate at 2**CNT_W-1; saturation sets OVF at LATCH.
//  START while BUSY ignored. ABORT in any state -> IDLE next cycle; COUNT regs and DONE unchanged.
//  ABORT and START in same write: ABORT wins. Clearing CONT mid-run: current window completes.
//  WINDOW/CH_SEL writes take effect immediately; WINDOW change mid-run applies at next ARM.
//  CH_SEL >= NUM_CH -> export_data=0. DONE set in LATCH and W1C on same cycle: set wins.
//  export_data updates the cycle after LATCH or CH_SEL write.
// STRUCTURE
//  Package ro_mon_pkg: register offsets, CTRL/STATUS bit indices, state enum {IDLE,ARM,COUNT,LATCH}.
//  Sub-module ro_edge_counter (one per channel, generate loop): sync, edge detect, saturating
//   CNT_W counter with clr/en inputs and sat output. Top holds FSM, window counter, register file.
// TESTING
//  1 Reset, read all regs -> WINDOW=1000, others 0, irq=0, export_data=0.
//  2 ro_in[0]=clk/4 square, WINDOW=100, START -> COUNT[0]=25 (+/-1), BUSY low after 102 cycles, DONE=1.
//  3 IRQ_EN=1, run -> irq rises with DONE; W1C STATUS=0x2 -> irq=0 next cycle.
//  4 CNT_W=8, ro_in=clk/4, WINDOW=2000 -> COUNT=255, OVF=1; W1C 0x4 clears OVF.
//  5 CONT=1, WINDOW=50: 3 back-to-back windows, DONE each; ABORT mid-window -> IDLE, COUNT unchanged.
//  6 WINDOW=0 -> behaves as 1; CH_SEL=NUM_CH -> export_data=0; START during BUSY ignored.

Source files
------------

// File: rtl/ro_mon_pkg.sv
// Shared definitions for the ring-oscillator frequency monitor: register map,
// control/status bit positions, FSM state encodings and the window-load helper.
package ro_mon_pkg;

  // Avalon word offsets
  localparam int REG_CTRL       = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_WINDOW     = 2;
  localparam int REG_CHSEL      = 3;
  localparam int REG_COUNT_BASE = 4;

  // CTRL bits (START and ABORT are write-only pulses)
  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 3;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  // Measurement FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // A programmed window of zero is treated as a one-cycle window so the
  // down-counter never wraps.
  function automatic logic [31:0] win_load(input logic [31:0] win);
    return (win == 32'd0) ? 32'd1 : win;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One ring-oscillator channel: two-flop synchroniser plus a delay flop for
// rising-edge detection, feeding a saturating edge counter with clear/enable.
module ro_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_det;

  // sync_q[0..1] resynchronise the async input, sync_q[2] delays for edge detect
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign sat      = &cnt_q;
  assign cnt      = cnt_q;

  // Next-state: shift the synchroniser and advance the counter, holding at all-ones
  always_comb begin
    sync_d = {sync_q[1:0], ro_in};
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && edge_det && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_freq_monitor.sv
// N-channel ring-oscillator frequency monitor. Counts oscillator edges over a
// programmable window of clock cycles, latches per-channel results into an
// Avalon-MM readable register file and exports the selected channel.
module ro_freq_monitor
  import ro_mon_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int          ADDR_W      = 5,
  parameter int unsigned WIN_DEFAULT = 1000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [NUM_CH-1:0] ro_in,
  output logic              irq,
  output logic [31:0]       export_data
);

  logic [1:0]  state_q, state_d;
  logic [31:0] win_cnt_q, win_cnt_d;
  logic [31:0] window_q, window_d;
  logic [31:0] ch_sel_q, ch_sel_d;
  logic        cont_q, cont_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] export_q, export_d;

  logic        wr_ctrl, wr_status, wr_window, wr_chsel;
  logic        start_req, abort_req;
  logic        latch_en, busy;
  logic        live_clr, live_en;

  logic [NUM_CH-1:0] live_sat;
  logic [31:0]       count_ext      [NUM_CH];
  logic [31:0]       count_next_ext [NUM_CH];

  assign wr_ctrl   = avs_write && (avs_address == ADDR_W'(REG_CTRL));
  assign wr_status = avs_write && (avs_address == ADDR_W'(REG_STATUS));
  assign wr_window = avs_write && (avs_address == ADDR_W'(REG_WINDOW));
  assign wr_chsel  = avs_write && (avs_address == ADDR_W'(REG_CHSEL));
  assign start_req = wr_ctrl && avs_writedata[CTRL_START];
  assign abort_req = wr_ctrl && avs_writedata[CTRL_ABORT];

  assign busy     = (state_q != ST_IDLE);
  assign live_clr = (state_q == ST_ARM);
  assign live_en  = (state_q == ST_COUNT);

  assign irq          = done_q & irq_en_q;
  assign avs_readdata = readdata_q;
  assign export_data  = export_q;

  // Per-channel edge counter plus its latched COUNT register
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] live_cnt;
      logic [CNT_W-1:0] count_q, count_d;

      ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .ro_in (ro_in[gi]),
        .clr   (live_clr),
        .en    (live_en),
        .cnt   (live_cnt),
        .sat   (live_sat[gi])
      );

      // Capture the live count at the end of each window
      always_comb begin
        count_d = latch_en ? live_cnt : count_q;
      end

      // Latched result register
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign count_ext[gi]      = 32'(count_q);
      assign count_next_ext[gi] = 32'(count_d);
    end
  endgenerate

  // Measurement FSM and window down-counter; ABORT overrides everything
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    latch_en  = 1'b0;
    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) state_d = ST_ARM;
        end
        ST_ARM: begin
          win_cnt_d = win_load(window_q);
          state_d   = ST_COUNT;
        end
        ST_COUNT: begin
          win_cnt_d = win_cnt_q - 32'd1;
          if (win_cnt_q == 32'd1) state_d = ST_LATCH;
        end
        default: begin
          latch_en = 1'b1;
          state_d  = cont_q ? ST_ARM : ST_IDLE;
        end
      endcase
    end
  end

  // Register file updates; a LATCH-cycle set beats a same-cycle W1C
  always_comb begin
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    window_d = window_q;
    ch_sel_d = ch_sel_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    if (wr_ctrl) begin
      cont_d   = avs_writedata[CTRL_CONT];
      irq_en_d = avs_writedata[CTRL_IRQ_EN];
    end
    if (wr_window) window_d = avs_writedata;
    if (wr_chsel)  ch_sel_d = avs_writedata;
    if (wr_status) begin
      if (avs_writedata[STAT_DONE]) done_d = 1'b0;
      if (avs_writedata[STAT_OVF])  ovf_d  = 1'b0;
    end
    if (latch_en) begin
      done_d = 1'b1;
      if (|live_sat) ovf_d = 1'b1;
    end
  end

  // Read mux, registered for a fixed one-cycle latency; idle cycles return 0
  always_comb begin
    readdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_W'(REG_CTRL): begin
          readdata_d[CTRL_CONT]   = cont_q;
          readdata_d[CTRL_IRQ_EN] = irq_en_q;
        end
        ADDR_W'(REG_STATUS): begin
          readdata_d[STAT_BUSY] = busy;
          readdata_d[STAT_DONE] = done_q;
          readdata_d[STAT_OVF]  = ovf_q;
        end
        ADDR_W'(REG_WINDOW): readdata_d = window_q;
        ADDR_W'(REG_CHSEL):  readdata_d = ch_sel_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == ADDR_W'(REG_COUNT_BASE + i)) readdata_d = count_ext[i];
          end
        end
      endcase
    end
  end

  // Export mux uses next-state values so it tracks LATCH and CH_SEL writes one edge later
  always_comb begin
    export_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel_d == 32'(i)) export_d = count_next_ext[i];
    end
  end

  // Control and status registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      window_q   <= 32'(WIN_DEFAULT);
      ch_sel_q   <= '0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      readdata_q <= '0;
      export_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      window_q   <= window_d;
      ch_sel_q   <= ch_sel_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
      export_q   <= export_d;
    end
  end

endmodule

// File: tb/tb_ro_freq_monitor.sv
// Directed bench for ro_freq_monitor: a 4-channel/32-bit instance for the
// main scenarios and a 2-channel/8-bit instance for counter saturation.
module tb_ro_freq_monitor;

  logic        clk;
  logic        rst_n;
  logic        ro_en;
  logic        ro0, ro1;
  logic [3:0]  ro_in;

  logic [4:0]  a_addr, b_addr;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_wd, b_wd;
  logic [31:0] a_rdata, b_rdata;
  logic        a_irq, b_irq;
  logic [31:0] a_export, b_export;

  int checks;
  int errors;

  ro_freq_monitor #(.NUM_CH(4), .CNT_W(32), .ADDR_W(5), .WIN_DEFAULT(1000)) u_dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (a_addr),
    .avs_read      (a_rd),
    .avs_write     (a_wr),
    .avs_writedata (a_wd),
    .avs_readdata  (a_rdata),
    .ro_in         (ro_in),
    .irq           (a_irq),
    .export_data   (a_export)
  );

  ro_freq_monitor #(.NUM_CH(2), .CNT_W(8), .ADDR_W(5), .WIN_DEFAULT(1000)) u_dut8 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (b_addr),
    .avs_read      (b_rd),
    .avs_write     (b_wr),
    .avs_writedata (b_wd),
    .avs_readdata  (b_rdata),
    .ro_in         (ro_in[1:0]),
    .irq           (b_irq),
    .export_data   (b_export)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ro0 = clk/4, ro1 = clk/8; both toggle on falling clock edges
  initial begin
    ro0 = 1'b0;
    ro1 = 1'b0;
  end
  always #20 ro0 = ro_en ? ~ro0 : 1'b0;
  always #40 ro1 = ro_en ? ~ro1 : 1'b0;
  assign ro_in = {2'b00, ro1, ro0};

  task automatic bus_wr(input int dut, input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    if (dut == 0) begin a_addr = 5'(addr); a_wd = data; a_wr = 1'b1; end
    else          begin b_addr = 5'(addr); b_wd = data; b_wr = 1'b1; end
    @(posedge clk); #1;
    a_wr = 1'b0;
    b_wr = 1'b0;
    $display("[%0t] dut%0d WR addr=%0d data=0x%08h", $time, dut, addr, data);
  endtask

  task automatic bus_rd(input int dut, input int addr, output logic [31:0] data);
    @(posedge clk); #1;
    if (dut == 0) begin a_addr = 5'(addr); a_rd = 1'b1; end
    else          begin b_addr = 5'(addr); b_rd = 1'b1; end
    @(posedge clk); #1;
    data = (dut == 0) ? a_rdata : b_rdata;
    a_rd = 1'b0;
    b_rd = 1'b0;
    $display("[%0t] dut%0d RD addr=%0d data=0x%08h", $time, dut, addr, data);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_val;
    checks++;
    if (a_rdata !== 32'd0 || a_irq !== 1'b0 || a_export !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: readdata=0x%08h irq=%b export=0x%08h, required all 0", a_rdata, a_irq, a_export);
    end
    for (int addr = 0; addr < 9; addr++) begin
      bus_rd(0, addr, rd);
      exp_val = (addr == 2) ? 32'd1000 : 32'd0;
      checks++;
      if (rd !== exp_val) begin
        errors++;
        $display("FAIL reset_reg%0d: got 0x%08h, required 0x%08h", addr, rd, exp_val);
      end
    end
  endtask

  task automatic test_single_window();
    logic [31:0] rd;
    ro_en = 1'b1;
    repeat (10) @(posedge clk);
    bus_wr(0, 2, 32'd100);
    bus_wr(0, 0, 32'h1);
    repeat (100) @(posedge clk);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL window_latch_busy: STATUS=0x%08h, required 0x00000001", rd);
    end
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL window_done: STATUS=0x%08h, required 0x00000002", rd);
    end
    bus_rd(0, 4, rd);
    checks++;
    if (rd < 32'd24 || rd > 32'd26) begin
      errors++;
      $display("FAIL count0_clk_div4: got %0d, required 24..26", rd);
    end
    bus_rd(0, 5, rd);
    checks++;
    if (rd < 32'd12 || rd > 32'd13) begin
      errors++;
      $display("FAIL count1_clk_div8: got %0d, required 12..13", rd);
    end
    checks++;
    if (a_export < 32'd24 || a_export > 32'd26) begin
      errors++;
      $display("FAIL export_ch0: got %0d, required 24..26", a_export);
    end
    bus_wr(0, 1, 32'h2);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL done_w1c: STATUS=0x%08h, required 0x00000000", rd);
    end
  endtask

  task automatic test_irq();
    bit seen;
    bus_wr(0, 2, 32'd10);
    bus_wr(0, 0, 32'h4);
    checks++;
    if (a_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: irq=%b, required 0", a_irq);
    end
    bus_wr(0, 0, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (a_irq === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL irq_rise: irq=%b after 40 cycles, required 1", a_irq);
    end
    bus_wr(0, 1, 32'h2);
    checks++;
    if (a_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c: irq=%b, required 0", a_irq);
    end
    bus_wr(0, 0, 32'h0);
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    bus_wr(1, 2, 32'd2000);
    bus_wr(1, 0, 32'h1);
    repeat (2010) @(posedge clk);
    bus_rd(1, 4, rd);
    checks++;
    if (rd !== 32'd255) begin
      errors++;
      $display("FAIL sat_count: got %0d, required 255", rd);
    end
    checks++;
    if (b_export !== 32'd255) begin
      errors++;
      $display("FAIL sat_export: got %0d, required 255", b_export);
    end
    bus_rd(1, 1, rd);
    checks++;
    if (rd !== 32'h6) begin
      errors++;
      $display("FAIL sat_status: STATUS=0x%08h, required 0x00000006", rd);
    end
    bus_wr(1, 1, 32'h4);
    bus_rd(1, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL ovf_w1c: STATUS=0x%08h, required 0x00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] c_prev;
    bit          seen;
    c_prev = '0;
    bus_wr(0, 2, 32'd50);
    bus_wr(0, 0, 32'h3);
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      rd   = '0;
      for (int p = 0; p < 100 && !seen; p++) begin
        bus_rd(0, 1, rd);
        if (rd[1] === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || rd[0] !== 1'b1) begin
        errors++;
        $display("FAIL cont_window%0d: STATUS=0x%08h, required DONE=1 BUSY=1", k, rd);
      end
      if (k < 2) bus_wr(0, 1, 32'h2);
      bus_rd(0, 4, c_prev);
      checks++;
      if (c_prev < 32'd12 || c_prev > 32'd13) begin
        errors++;
        $display("FAIL cont_count%0d: got %0d, required 12..13", k, c_prev);
      end
    end
    ro_en = 1'b0;
    repeat (10) @(posedge clk);
    bus_wr(0, 0, 32'h8);
    repeat (80) @(posedge clk);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL abort_status: STATUS=0x%08h, required 0x00000002", rd);
    end
    bus_rd(0, 4, rd);
    checks++;
    if (rd !== c_prev) begin
      errors++;
      $display("FAIL abort_count: got %0d, required %0d", rd, c_prev);
    end
  endtask

  task automatic test_edge_cases();
    logic [31:0] rd;
    ro_en = 1'b1;
    bus_wr(0, 0, 32'h9);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL abort_beats_start: STATUS=0x%08h, required 0x00000002", rd);
    end
    bus_wr(0, 1, 32'h2);
    bus_wr(0, 2, 32'd0);
    bus_rd(0, 2, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL window_zero_rb: got %0d, required 0", rd);
    end
    bus_wr(0, 0, 32'h1);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL window_zero_busy: STATUS=0x%08h, required 0x00000001", rd);
    end
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL window_zero_done: STATUS=0x%08h, required 0x00000002", rd);
    end
    bus_wr(0, 1, 32'h2);
    bus_wr(0, 2, 32'd100);
    bus_wr(0, 0, 32'h1);
    bus_wr(0, 0, 32'h1);
    repeat (99) @(posedge clk);
    bus_rd(0, 1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL start_while_busy: STATUS=0x%08h, required 0x00000002", rd);
    end
    checks++;
    if (a_export < 32'd24 || a_export > 32'd26) begin
      errors++;
      $display("FAIL export_sel0: got %0d, required 24..26", a_export);
    end
    bus_wr(0, 3, 32'd1);
    checks++;
    if (a_export < 32'd12 || a_export > 32'd13) begin
      errors++;
      $display("FAIL export_sel1: got %0d, required 12..13", a_export);
    end
    bus_wr(0, 3, 32'd4);
    checks++;
    if (a_export !== 32'd0) begin
      errors++;
      $display("FAIL export_sel_oob: got %0d, required 0", a_export);
    end
    bus_rd(0, 3, rd);
    checks++;
    if (rd !== 32'd4) begin
      errors++;
      $display("FAIL chsel_rb: got %0d, required 4", rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ro_en  = 1'b0;
    rst_n  = 1'b0;
    a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wd = '0;
    b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wd = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_window();
    test_irq();
    test_saturation();
    test_back_to_back();
    test_edge_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
